// File: rtl/count_sequencer.sv
// count_sequencer
//
// Control stage that sits directly upstream of a WIDTH-bit loadable
// up-counter. On START it captures a start and a stop value. It then
// loads the start value into the counter and enables counting. When the
// counter output reaches the stop value it stops the counter and pulses
// DONE for one cycle. ABORT cancels an active run. The counter then holds
// whatever value it had reached, and no DONE is produced.
//
// Ports
//   CLK        in   system clock, rising edge active
//   RST        in   asynchronous, active-low reset
//   START      in   run request, sampled only in IDLE
//   ABORT      in   cancel request, sampled in LDST and CNT
//   START_VAL  in   value to load into the counter (captured on START)
//   STOP_VAL   in   terminal count value (captured on START)
//   COUNT      in   counter output, fed back
//   LOAD       out  counter parallel-load control
//   ENA        out  counter enable (combinational from COUNT and ABORT)
//   DATA       out  counter load data (always the captured start value)
//   BUSY       out  run in progress (LDST or CNT)
//   DONE       out  one-cycle completion pulse
module count_sequencer #(
    parameter int WIDTH = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic [WIDTH-1:0] START_VAL,
    input  logic [WIDTH-1:0] STOP_VAL,
    input  logic [WIDTH-1:0] COUNT,
    output logic             LOAD,
    output logic             ENA,
    output logic [WIDTH-1:0] DATA,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LDST = 2'd1,
        S_CNT  = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] stop_q,  stop_d;

    logic at_stop;
    assign at_stop = (COUNT == stop_q);

    // NOTE: every signal is defaulted to its held value first, so that a
    // branch which does not assign it cannot infer a latch.
    always_comb begin
        state_d = state_q;
        start_d = start_q;
        stop_d  = stop_q;
        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    start_d = START_VAL;
                    stop_d  = STOP_VAL;
                    state_d = S_LDST;
                end
            end
            S_LDST: state_d = ABORT ? S_IDLE : S_CNT;
            S_CNT: begin
                // ABORT wins over a simultaneous stop match.
                if (ABORT)        state_d = S_IDLE;
                else if (at_stop) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. The
    // captured values are plain registers, not memories, so they get a
    // defined reset value like the state.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            start_q <= '0;
            stop_q  <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            stop_q  <= stop_d;
        end
    end

    assign DATA = start_q;
    assign LOAD = (state_q == S_LDST);
    assign BUSY = (state_q == S_LDST) || (state_q == S_CNT);
    assign DONE = (state_q == S_FIN);

    // ENA drops in the very cycle COUNT reaches the stop value. The counter
    // therefore holds exactly stop_q and never overshoots. ABORT also drops
    // ENA immediately rather than one cycle late.
    assign ENA = ((state_q == S_LDST) && !ABORT) ||
                 ((state_q == S_CNT)  && !ABORT && !at_stop);

endmodule
